// File: rtl/router_nic.sv
// router_nic: one-packet ingress/egress NIC between a PE and a mesh router local port.
// Define NIC_POLARITY_GATE_EN to allow injection only on cycles whose polarity matches the packet VC bit.
module router_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nic_en,
    input  logic                  nic_wr_en,
    input  logic                  polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do
);

    localparam logic [1:0] ADDR_IN_BUF     = 2'd0;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'd2;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'd3;

    logic [DATA_WIDTH-1:0] in_buf_reg,  in_buf_next;
    logic [DATA_WIDTH-1:0] out_buf_reg, out_buf_next;
    logic                  in_full_reg,  in_full_next;
    logic                  out_full_reg, out_full_next;

    logic pe_rd;
    logic pe_wr;
    logic eject_capture;
    logic ingress_read;
    logic egress_load;
    logic vc_ok;

    assign pe_rd = nic_en & ~nic_wr_en;
    assign pe_wr = nic_en &  nic_wr_en;

    // A router send while full is a protocol violation; the data is simply not captured.
    assign net_ri        = ~in_full_reg;
    assign eject_capture = net_si & net_ri;
    assign ingress_read  = pe_rd & (addr == ADDR_IN_BUF);
    assign egress_load   = pe_wr & (addr == ADDR_OUT_BUF) & ~out_full_reg;

`ifdef NIC_POLARITY_GATE_EN
    assign vc_ok = (out_buf_reg[DATA_WIDTH-1] == polarity);
`else
    assign vc_ok = 1'b1;
`endif

    assign net_so = out_full_reg & net_ro & vc_ok;
    assign net_do = out_buf_reg;

    always_comb begin
        d_out = '0;
        if (pe_rd) begin
            case (addr)
                ADDR_IN_BUF:     d_out = in_buf_reg;
                ADDR_IN_STATUS:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full_reg};
                ADDR_OUT_BUF:    d_out = out_buf_reg;
                ADDR_OUT_STATUS: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full_reg};
                default:         d_out = '0;
            endcase
        end
    end

    // Capture needs an empty buffer, so it can never collide with a real ingress read.
    always_comb begin
        in_buf_next  = in_buf_reg;
        in_full_next = in_full_reg;
        if (eject_capture) begin
            in_buf_next  = net_di;
            in_full_next = 1'b1;
        end else if (ingress_read) begin
            in_full_next = 1'b0;
        end
    end

    // Load needs an empty buffer and injection a full one, so the two are exclusive.
    always_comb begin
        out_buf_next  = out_buf_reg;
        out_full_next = out_full_reg;
        if (net_so) begin
            out_full_next = 1'b0;
        end else if (egress_load) begin
            out_buf_next  = d_in;
            out_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf_reg   <= '0;
            in_full_reg  <= 1'b0;
            out_buf_reg  <= '0;
            out_full_reg <= 1'b0;
        end else begin
            in_buf_reg   <= in_buf_next;
            in_full_reg  <= in_full_next;
            out_buf_reg  <= out_buf_next;
            out_full_reg <= out_full_next;
        end
    end

endmodule

// File: doc/router_nic.md
# router_nic

Network interface controller between a processing element (PE) and the local port of a mesh router. It sits directly upstream of the router input channel, injecting 64-bit packets with the `send`/`ready` handshake. It sits directly downstream of the router output channel, ejecting packets with the same handshake. The PE sees four memory-mapped registers: an ingress buffer, an ingress status, an egress buffer and an egress status. Each buffer holds one packet.

## Interface

Parameters:
- `DATA_WIDTH`, 64, packet width. Bit `DATA_WIDTH-1` is the virtual-channel (VC) bit.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `addr` in 2: PE register select. 0 = ingress buffer, 1 = ingress status, 2 = egress buffer, 3 = egress status.
- `d_in` in DATA_WIDTH: PE write data.
- `d_out` out DATA_WIDTH: PE read data, combinational.
- `nic_en` in 1: PE access enable.
- `nic_wr_en` in 1: write when high, read when low; only meaningful with `nic_en`.
- `polarity` in 1: router cycle polarity, toggles every cycle.
- `net_si` in 1: router output channel presents a packet (send in).
- `net_ri` out 1: NIC can accept an ejected packet (ready out).
- `net_di` in DATA_WIDTH: ejected packet from the router.
- `net_so` out 1: NIC injects a packet this cycle (send out).
- `net_ro` in 1: router input channel ready.
- `net_do` out DATA_WIDTH: injected packet.

## Operation

- **State:** `in_buf`, `in_full`, `out_buf`, `out_full`. Reset clears all four to 0.
- **Ejection (router → NIC):**
  - `net_ri = ~in_full`.
  - On an edge with `net_si && net_ri`: `in_buf <= net_di`, `in_full <= 1`.
  - `net_si` while full is a protocol violation by the router. Data is ignored.
- **PE ingress read:** `nic_en && !nic_wr_en && addr==0` returns `in_buf` on `d_out`, and clears `in_full` at that edge.
  - Reading while `in_full=0` returns the stale `in_buf` and has no effect.
- **PE status reads:**
  - `addr==1` returns `{63'b0, in_full}`.
  - `addr==3` returns `{63'b0, out_full}`.
  - `addr==2` read returns `out_buf`.
- `d_out = 0` whenever `nic_en=0` or `nic_wr_en=1`.
- **PE egress write:** `nic_en && nic_wr_en && addr==2 && !out_full` loads `out_buf <= d_in` and sets `out_full`.
  - A write while full is dropped; the buffer and flag are unchanged.
  - Writes to addr 0, 1 and 3 are ignored.
- **Injection (NIC → router):**
  - `net_so = out_full && net_ro && vc_ok`.
  - `vc_ok = (out_buf[DATA_WIDTH-1] == polarity)`. This means a packet injects only on cycles whose polarity matches its VC bit.
  - `net_do = out_buf` at all times.
  - On an edge with `net_so=1`: `out_full <= 0`.
- **Simultaneous events:**
  - PE egress write in the same cycle as `net_so=1`: the write is dropped, because `out_full` was 1 when sampled. The buffer empties at that edge.
  - Ejection capture and an ingress read cannot coincide, since capture requires `in_full=0`.
- **Reset mid-operation:** any buffered packet is discarded. `net_so`, `in_full` and `out_full` are 0 in the cycle after reset is sampled.

## Timing

- **Reset values of outputs:** `net_ri=1`, `net_so=0`, `net_do=0`, `d_out=0`.
- **Ejection:** `net_si` sampled at edge N gives `in_full=1`, `net_ri=0` and addr-1 read = 1 during cycle N+1.
- **Ingress read:** a read at edge N gives `net_ri=1` in cycle N+1.
- **Egress write:** a write at edge N gives `out_full=1` in cycle N+1.
  - `net_so` can assert combinationally in cycle N+1 if `net_ro` is high and polarity matches. Otherwise it asserts on the first later matching cycle.
  - Worst-case wait with `net_ro` held high is one extra cycle.
- **Throughput:**
  - Ejection: one packet per two cycles, since full blocks until read.
  - Injection: one packet per two cycles with back-to-back PE writes.
- **`net_ro` deasserted:** the packet holds. `net_so=0` and `net_do` stays stable.

## Configuration

- Macro `NIC_POLARITY_GATE_EN`.
  - Defined: `vc_ok` is the polarity match described above.
  - Undefined: `vc_ok=1`; injection occurs on any cycle with `out_full && net_ro`.
  - All other behaviour is identical.

## Test plan

- **Reset:** hold `reset` high for 2 cycles → `net_ri=1`, `net_so=0`, `net_do=0`, and status reads at addr 1 and addr 3 both return 0.
- **Ejection and read-back:**
  - `net_si=1`, `net_di=64'hFA50` for one cycle → `net_ri=0` next cycle, addr-1 read = 1.
  - Addr-0 read returns `64'hFA50` → `net_ri=1` next cycle.
- **Injection with polarity gate, `net_ro=1`:**
  - Write `64'h8000_0000_0000_6840` (VC=1) → `net_so` asserts only in a cycle with `polarity=1`, `net_do` equals the written value, then addr-3 read = 0.
  - Repeat with a VC=0 packet → `net_so` only in a `polarity=0` cycle.
- **Backpressure:** `net_ro=0`; write `64'hFFFF` → `net_so=0` for 5 cycles, `out_full=1`; raise `net_ro` → inject within 2 cycles.
- **Drop on full:** with `net_ro=0`, write `64'hC7D4` then `64'h1234` → `net_do` stays `64'hC7D4`; release → exactly one injection of `64'hC7D4`.
- **Reset mid-operation:** load both buffers, assert `reset` for 1 cycle → both status reads 0, no `net_so`, `net_ri=1`. Rerun the injection scenario with the macro undefined → `net_so` asserts in the first cycle after the write regardless of `polarity`.
